// File: rtl/clkdrv_pkg.sv
// Purpose: shared types and limits for the clock-driver stagger controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package clkdrv_pkg;

    // Legal range for the number of driver segments in the bank.
    localparam int NSEG_MIN = 2;
    localparam int NSEG_MAX = 32;

    // Sequencer states. OFF and ON are the settled states; the two ramp
    // states step EN one segment at a time.
    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    // True when the bank is fully off or fully on and no ramp is running.
    function automatic logic is_settled(input state_t st);
        return (st == ST_OFF) || (st == ST_ON);
    endfunction

endpackage

// File: rtl/clkdrv_stagger_ctrl_if.sv
// Purpose: bundles the level request, stagger interval and segment-enable status.
// Latency: n/a (wiring only).
// Backpressure: none; en_req is a level request, the status outputs are levels.
//
// Signals:
//   en_req  - 1 = all segments on, 0 = all segments off (driven by power/clock mgmt)
//   stagger - cycles between consecutive segment changes, 0 behaves as 1
//   en      - thermometer-coded segment enables, en[0] = first segment
//   ready   - bank settled (all off or all on), no ramp in progress
//   busy    - ramp in progress, always ~ready
interface clkdrv_stagger_ctrl_if #(
    parameter int NSEG  = 8,
    parameter int DLY_W = 4
);
    logic             en_req;
    logic [DLY_W-1:0] stagger;
    logic [NSEG-1:0]  en;
    logic             ready;
    logic             busy;

    // Management side: issues the request, observes the bank status.
    modport master (
        output en_req,
        output stagger,
        input  en,
        input  ready,
        input  busy
    );

    // Sequencer side.
    modport slave (
        input  en_req,
        input  stagger,
        output en,
        output ready,
        output busy
    );
endinterface

// File: rtl/clkdrv_stagger_tmr.sv
// Purpose: interval counter producing one step pulse every S = max(load,1) cycles.
// Latency: restart at edge k -> step high during the cycle ending at edge k+S.
// Backpressure: none; restart overrides any count in progress.
//
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   restart  - latch S from load and zero the counter on this edge
//   run      - counter advances only while high
//   load     - raw stagger value, 0 treated as 1
//   step     - single-cycle pulse, high when the counter has reached S-1
module clkdrv_stagger_tmr #(
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             run,
    input  logic [DLY_W-1:0] load,
    output logic             step
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] last_q;   // latched S-1, the count on which step fires
    logic [DLY_W-1:0] last_nxt;

    // max(load,1) - 1 without a separate compare-and-select on S.
    assign last_nxt = (load == '0) ? '0 : load - 1'b1;

    // Combinational off the registered count so the owner can act on the
    // same edge the interval expires.
    assign step = run && (cnt_q == last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else if (restart) begin
            cnt_q  <= '0;
            last_q <= last_nxt;
        end else if (run) begin
            cnt_q <= step ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/clkdrv_stagger_ctrl.sv
// Purpose: ramps a clock-driver segment bank on/off one segment per stagger interval.
// Latency: first segment changes on the edge the request is sampled; full swing after (NSEG-1)*S more edges.
// Backpressure: none; en_req is level-sensitive and may reverse a ramp at any time.
//
// Ports:
//   clk - single clock, rising edge
//   rst - synchronous active-high reset, clears EN immediately (no ramp-down)
//   ctl - slave side of clkdrv_stagger_ctrl_if (en_req, stagger in; en, ready, busy out)
module clkdrv_stagger_ctrl
    import clkdrv_pkg::*;
#(
    parameter int NSEG  = 8,
    parameter int DLY_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    clkdrv_stagger_ctrl_if.slave  ctl
);

    if (NSEG < NSEG_MIN || NSEG > NSEG_MAX) begin : g_nseg_range
        $error("clkdrv_stagger_ctrl: NSEG=%0d outside legal range %0d..%0d",
               NSEG, NSEG_MIN, NSEG_MAX);
    end

    if (DLY_W < 1) begin : g_dly_w_range
        $error("clkdrv_stagger_ctrl: DLY_W=%0d must be at least 1", DLY_W);
    end

    state_t          state_q;
    state_t          state_nxt;
    logic [NSEG-1:0] en_q;
    logic [NSEG-1:0] en_nxt;
    logic [NSEG-1:0] en_up;
    logic [NSEG-1:0] en_dn;
    logic            ready_q;
    logic            busy_q;
    logic            tmr_restart;
    logic            tmr_run;
    logic            tmr_step;

    // Thermometer moves: one more segment on, or the highest one off.
    // Only these two updates ever touch EN, so EN stays 0..01..1.
    assign en_up = {en_q[NSEG-2:0], 1'b1};
    assign en_dn = {1'b0, en_q[NSEG-1:1]};

    assign tmr_run = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

    clkdrv_stagger_tmr #(
        .DLY_W (DLY_W)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .restart (tmr_restart),
        .run     (tmr_run),
        .load    (ctl.stagger),
        .step    (tmr_step)
    );

    // A ramp start or a reversal moves EN on the sampling edge itself and
    // re-latches the interval; regular ramp steps wait for the timer. A
    // reversal takes priority over a step due on the same edge, so each
    // reversal moves EN by exactly one segment.
    always_comb begin
        state_nxt   = state_q;
        en_nxt      = en_q;
        tmr_restart = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                if (ctl.en_req) begin
                    en_nxt      = en_up;
                    tmr_restart = 1'b1;
                    state_nxt   = ST_RAMP_UP;
                end
            end

            ST_RAMP_UP: begin
                if (!ctl.en_req) begin
                    en_nxt      = en_dn;
                    tmr_restart = 1'b1;
                    // Reversing from a single segment lands straight in OFF.
                    state_nxt   = (en_dn == '0) ? ST_OFF : ST_RAMP_DOWN;
                end else if (tmr_step) begin
                    en_nxt    = en_up;
                    state_nxt = (&en_up) ? ST_ON : ST_RAMP_UP;
                end
            end

            ST_ON: begin
                if (!ctl.en_req) begin
                    en_nxt      = en_dn;
                    tmr_restart = 1'b1;
                    state_nxt   = ST_RAMP_DOWN;
                end
            end

            ST_RAMP_DOWN: begin
                if (ctl.en_req) begin
                    en_nxt      = en_up;
                    tmr_restart = 1'b1;
                    // Reversing one segment short of full lands straight in ON.
                    state_nxt   = (&en_up) ? ST_ON : ST_RAMP_UP;
                end else if (tmr_step) begin
                    en_nxt    = en_dn;
                    state_nxt = (en_dn == '0) ? ST_OFF : ST_RAMP_DOWN;
                end
            end

            default: begin
                state_nxt = ST_OFF;
                en_nxt    = '0;
            end
        endcase
    end

    // READY/BUSY are registered from the next state so they change on the
    // same edge as the EN update that settles or unsettles the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            en_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            en_q    <= en_nxt;
            ready_q <= is_settled(state_nxt);
            busy_q  <= !is_settled(state_nxt);
        end
    end

    assign ctl.en    = en_q;
    assign ctl.ready = ready_q;
    assign ctl.busy  = busy_q;

endmodule

// File: tb/tb_clkdrv_stagger_ctrl.sv
module tb_clkdrv_stagger_ctrl;

    localparam int NSEG  = 8;
    localparam int DLY_W = 4;

    typedef struct {
        int         cyc;
        logic [7:0] en;
        logic       rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clkdrv_stagger_ctrl_if #(.NSEG(NSEG), .DLY_W(DLY_W)) bus ();

    clkdrv_stagger_ctrl #(.NSEG(NSEG), .DLY_W(DLY_W)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus.slave)
    );

    exp_t       exp_q[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    bit         mon_on = 1'b0;
    logic [7:0] prev_en;
    logic       prev_rdy;
    int         k;

    // cyc == c after rising edge number c.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of EN or READY must match the next scheduled entry.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.en !== prev_en || bus.ready !== prev_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: cyc=%0d en=%h ready=%b, required no change (en=%h ready=%b)",
                             cyc, bus.en, bus.ready, prev_en, prev_rdy);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cyc || bus.en !== e.en || bus.ready !== e.rdy) begin
                        n_bad++;
                        $display("FAIL en_step: got cyc=%0d en=%h ready=%b, required cyc=%0d en=%h ready=%b",
                                 cyc, bus.en, bus.ready, e.cyc, e.en, e.rdy);
                    end
                end
            end
            n_cmp++;
            if ((bus.en & 8'(bus.en + 8'd1)) != 8'd0 || bus.busy !== ~bus.ready) begin
                n_bad++;
                $display("FAIL invariant: cyc=%0d en=%h busy=%b ready=%b, required thermometer en and busy==~ready",
                         cyc, bus.en, bus.busy, bus.ready);
            end
        end
        prev_en  = bus.en;
        prev_rdy = bus.ready;
    end

    task automatic push(input int c, input logic [7:0] en_v, input logic rdy_v);
        exp_t x;
        x.cyc = c;
        x.en  = en_v;
        x.rdy = rdy_v;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Wait until the negedge following rising edge c.
    task automatic at_cyc(input int c);
        int g = 0;
        while (cyc < c && g < 2000) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Wait for every scheduled change to be seen, bounded.
    task automatic drain(input string nm, input int lim);
        int g = 0;
        while (exp_q.size() != 0 && g < lim) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s timeout: %0d changes outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en_req  = 1'b0;
        bus.stagger = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_en",    32'(bus.en),    32'h00);
        chk("rst_ready", 32'(bus.ready), 32'h1);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_en",    32'(bus.en),    32'h00);
        chk("idle_ready", 32'(bus.ready), 32'h1);
        mon_on = 1'b1;

        // Ramp up, S=3: 01 at k, one more bit every 3 edges, FF at k+21.
        bus.stagger = 4'd3;
        bus.en_req  = 1'b1;
        k = cyc + 1;
        push(k +  0, 8'h01, 1'b0);
        push(k +  3, 8'h03, 1'b0);
        push(k +  6, 8'h07, 1'b0);
        push(k +  9, 8'h0F, 1'b0);
        push(k + 12, 8'h1F, 1'b0);
        push(k + 15, 8'h3F, 1'b0);
        push(k + 18, 8'h7F, 1'b0);
        push(k + 21, 8'hFF, 1'b1);
        drain("ramp_up_s3", 60);
        chk("on_en", 32'(bus.en), 32'hFF);

        // Ramp down, STAGGER=0 behaves as 1: 8 consecutive edges.
        bus.stagger = 4'd0;
        bus.en_req  = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < 8; i++) push(k + i, 8'hFF >> (i + 1), i == 7);
        drain("ramp_down_s0", 30);
        chk("off_en", 32'(bus.en), 32'h00);

        // Reversal at 0F during ramp-up, S=2: 07 on the next edge, then down.
        bus.stagger = 4'd2;
        bus.en_req  = 1'b1;
        k = cyc + 1;
        push(k + 0, 8'h01, 1'b0);
        push(k + 2, 8'h03, 1'b0);
        push(k + 4, 8'h07, 1'b0);
        push(k + 6, 8'h0F, 1'b0);
        at_cyc(k + 6);
        bus.en_req = 1'b0;
        push(k +  7, 8'h07, 1'b0);
        push(k +  9, 8'h03, 1'b0);
        push(k + 11, 8'h01, 1'b0);
        push(k + 13, 8'h00, 1'b1);
        at_cyc(k + 7);
        chk("rev_busy", 32'(bus.busy), 32'h1);
        drain("reversal_0f", 40);

        // One-cycle request pulse: 01 then straight back to OFF.
        bus.stagger = 4'd5;
        bus.en_req  = 1'b1;
        k = cyc + 1;
        push(k, 8'h01, 1'b0);
        at_cyc(k);
        bus.en_req = 1'b0;
        push(k + 1, 8'h00, 1'b1);
        drain("single_bit_rev", 20);

        // STAGGER 3 -> 7 mid-ramp keeps S=3; the next ramp latches 7.
        bus.stagger = 4'd3;
        bus.en_req  = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 8; i++) push(k + 3 * i, 8'((1 << (i + 1)) - 1), i == 7);
        at_cyc(k + 1);
        bus.stagger = 4'd7;
        drain("midramp_stagger", 60);
        bus.en_req = 1'b0;
        k = cyc + 1;
        for (int i = 0; i < 8; i++) push(k + 7 * i, 8'hFF >> (i + 1), i == 7);
        drain("fresh_s7_down", 100);

        // Reset at 3F mid-ramp clears EN on that edge; held request restarts at 01.
        bus.stagger = 4'd1;
        bus.en_req  = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 6; i++) push(k + i, 8'((1 << (i + 1)) - 1), 1'b0);
        at_cyc(k + 5);
        rst = 1'b1;
        push(k + 6, 8'h00, 1'b1);
        at_cyc(k + 6);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push(k + 7 + i, 8'((1 << (i + 1)) - 1), i == 7);
        drain("rst_midramp", 40);

        // Stable request matching the settled state: nothing may move.
        repeat (12) @(negedge clk);
        chk("quiet_en",    32'(bus.en),    32'hFF);
        chk("quiet_ready", 32'(bus.ready), 32'h1);
        chk("quiet_queue", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
